mem_access_stage: RTL

- Memory-access pipeline stage that sits between the execute stage and the 16-word data memory.
- Converts ALU byte addresses into word indices and drives the memory write/read ports.
- Sequences the memory's one-cycle registered read and hands load, store and ALU results to writeback.
- Flags illegal accesses and counts completed memory operations.

---
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// Memory-access pipeline stage between the execute stage and a DEPTH-word
// data memory with a one-cycle registered read port.
//   * ALU ops pass straight through to writeback (1 op/cycle).
//   * Stores drive the memory write port for one cycle (1 op/cycle).
//   * Loads issue the read address, wait for the registered read, and then
//     hand the data to writeback (two bubble cycles).
//   * Misaligned, out-of-range or load+store ops are dropped and raise a
//     sticky fault that records the first offending address.
//   * Completed loads and stores are counted with a saturating counter.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid / ex_ready       execute-stage handshake (ready only in IDLE)
//   ex_is_load, ex_is_store   op type
//   ex_alu_result             byte address (mem ops) or result (ALU ops)
//   ex_store_data             store data
//   ex_rd, ex_reg_we          destination register and its write enable
//   mem_wr_addr, mem_reg_wr,
//   mem_wr_din                memory write port
//   mem_rd_addr, mem_rd_dat   memory read port (data one edge after addr)
//   wb_valid, wb_rd, wb_data,
//   wb_reg_we                 writeback payload, wb_valid is a 1-cycle pulse
//   fault, fault_addr         sticky illegal-access flag and first address
//   mem_op_count              saturating count of completed loads/stores
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  output logic [AW-1:0]     mem_wr_addr,
  output logic [AW-1:0]     mem_rd_addr,
  output logic              mem_reg_wr,
  output logic [DATA_W-1:0] mem_wr_din,
  input  logic [DATA_W-1:0] mem_rd_dat,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_we,
  output logic              fault,
  output logic [DATA_W-1:0] fault_addr,
  output logic [15:0]       mem_op_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LD_ISSUE   = 2'd1,
    LD_CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Destination of an in-flight load; kept apart from wb_rd/wb_reg_we so the
  // writeback outputs keep their previous values during the load bubbles.
  logic [4:0] ld_rd_q, ld_rd_d;
  logic       ld_we_q, ld_we_d;

  logic [AW-1:0]     mem_wr_addr_d, mem_rd_addr_d;
  logic              mem_reg_wr_d;
  logic [DATA_W-1:0] mem_wr_din_d;
  logic              wb_valid_d;
  logic [4:0]        wb_rd_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_reg_we_d;
  logic              fault_d;
  logic [DATA_W-1:0] fault_addr_d;
  logic [15:0]       mem_op_count_d;

  logic          accept;
  logic          is_mem;
  logic          illegal;
  logic [AW-1:0] word_index;
  logic [15:0]   count_inc;

  // ex_ready is a direct decode of the state register, so it is 1 out of
  // reset even though every other output resets to 0.
  assign ex_ready   = (state_q == IDLE);
  assign accept     = ex_valid && ex_ready;
  assign is_mem     = ex_is_load || ex_is_store;
  assign word_index = ex_alu_result[AW+1:2];
  assign illegal    = (ex_is_load && ex_is_store)
                   || (is_mem && (ex_alu_result[1:0] != 2'b00))
                   || (is_mem && (ex_alu_result >= DATA_W'(4 * DEPTH)));
  assign count_inc  = (mem_op_count == 16'hFFFF) ? mem_op_count
                                                 : mem_op_count + 16'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    state_d        = state_q;
    ld_rd_d        = ld_rd_q;
    ld_we_d        = ld_we_q;
    mem_wr_addr_d  = mem_wr_addr;
    mem_rd_addr_d  = mem_rd_addr;
    mem_reg_wr_d   = 1'b0;
    mem_wr_din_d   = mem_wr_din;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd;
    wb_data_d      = wb_data;
    wb_reg_we_d    = wb_reg_we;
    fault_d        = fault;
    fault_addr_d   = fault_addr;
    mem_op_count_d = mem_op_count;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            fault_d = 1'b1;
            if (!fault) fault_addr_d = ex_alu_result;
          end else if (ex_is_load) begin
            mem_rd_addr_d = word_index;
            ld_rd_d       = ex_rd;
            ld_we_d       = ex_reg_we && (ex_rd != 5'd0);
            state_d       = LD_ISSUE;
          end else if (ex_is_store) begin
            mem_reg_wr_d   = 1'b1;
            mem_wr_addr_d  = word_index;
            mem_wr_din_d   = ex_store_data;
            mem_op_count_d = count_inc;
          end else begin
            wb_valid_d  = 1'b1;
            wb_data_d   = ex_alu_result;
            wb_rd_d     = ex_rd;
            wb_reg_we_d = ex_reg_we && (ex_rd != 5'd0);
          end
        end
      end
      // Memory samples mem_rd_addr on this edge.
      LD_ISSUE: state_d = LD_CAPTURE;
      LD_CAPTURE: begin
        wb_valid_d     = 1'b1;
        wb_data_d      = mem_rd_dat;
        wb_rd_d        = ld_rd_q;
        wb_reg_we_d    = ld_we_q;
        mem_op_count_d = count_inc;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ld_rd_q      <= '0;
      ld_we_q      <= 1'b0;
      mem_wr_addr  <= '0;
      mem_rd_addr  <= '0;
      mem_reg_wr   <= 1'b0;
      mem_wr_din   <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_we    <= 1'b0;
      fault        <= 1'b0;
      fault_addr   <= '0;
      mem_op_count <= '0;
    end else begin
      state_q      <= state_d;
      ld_rd_q      <= ld_rd_d;
      ld_we_q      <= ld_we_d;
      mem_wr_addr  <= mem_wr_addr_d;
      mem_rd_addr  <= mem_rd_addr_d;
      mem_reg_wr   <= mem_reg_wr_d;
      mem_wr_din   <= mem_wr_din_d;
      wb_valid     <= wb_valid_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
      wb_reg_we    <= wb_reg_we_d;
      fault        <= fault_d;
      fault_addr   <= fault_addr_d;
      mem_op_count <= mem_op_count_d;
    end
  end

endmodule
